// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch with a registered output stage,
// ready/valid backpressure, branch redirect and a drain-on-stop FSM.
module fetch_unit #(
    parameter int mem_width  = 16,
    parameter int add_length = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  branch_en,
    input  logic [add_length-1:0] branch_target,
    output logic [add_length-1:0] address,
    output logic                  ce,
    input  logic [mem_width-1:0]  data,
    output logic [mem_width-1:0]  instr,
    output logic [add_length-1:0] instr_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  wrap
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [add_length-1:0] pc_q, pc_d;
    logic [mem_width-1:0]  instr_q, instr_d;
    logic [add_length-1:0] instr_addr_q, instr_addr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  wrap_q, wrap_d;
    logic                  hs;
    logic                  capture;

    assign hs      = instr_valid_q && instr_ready;
    assign ce      = (state_q == FETCH) && !branch_en && (!instr_valid_q || instr_ready);
    // Dropping enable in FETCH suppresses the capture even though ce is still raised.
    assign capture = ce && enable;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        instr_valid_d = instr_valid_q;
        wrap_d        = 1'b0;
        if (branch_en) begin
            pc_d          = branch_target;
            instr_valid_d = 1'b0;
            state_d       = (state_q == FETCH && enable) ? FETCH : IDLE;
        end else begin
            if (capture) begin
                instr_d       = data;
                instr_addr_d  = pc_q;
                instr_valid_d = 1'b1;
                pc_d          = pc_q + add_length'(1);
                wrap_d        = &pc_q;
            end else if (hs) begin
                instr_valid_d = 1'b0;
            end
            unique case (state_q)
                IDLE:    state_d = enable ? FETCH : IDLE;
                FETCH:   state_d = enable ? FETCH : ((instr_valid_q && !hs) ? DRAIN : IDLE);
                DRAIN:   state_d = enable ? FETCH : (hs ? IDLE : DRAIN);
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_addr_q  <= '0;
            instr_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            instr_valid_q <= instr_valid_d;
            wrap_q        <= wrap_d;
        end
    end

    assign address     = pc_q;
    assign instr       = instr_q;
    assign instr_addr  = instr_addr_q;
    assign instr_valid = instr_valid_q;
    assign wrap        = wrap_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter mem_width, default 16: instruction width in bits, equal to the program memory word width.
REQ-002 SHALL have parameter add_length, default 3: program counter and memory address width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: run request; high means fetch, low means stop after draining.
REQ-006 SHALL have port branch_en, input, 1 bit: redirect request, sampled on the clock edge.
REQ-007 SHALL have port branch_target, input, add_length bits: new program counter value when branch_en is high.
REQ-008 SHALL have port address, output, add_length bits: program memory address, equal to the pc register.
REQ-009 SHALL have port ce, output, 1 bit: program memory chip enable.
REQ-010 SHALL have port data, input, mem_width bits: program memory read data, combinational from address and ce.
REQ-011 SHALL have port instr, output, mem_width bits: registered instruction.
REQ-012 SHALL have port instr_addr, output, add_length bits: address that instr was fetched from.
REQ-013 SHALL have port instr_valid, output, 1 bit: instr holds an unconsumed instruction.
REQ-014 SHALL have port instr_ready, input, 1 bit: downstream accepts instr this cycle.
REQ-015 SHALL have port wrap, output, 1 bit: registered one-cycle pulse, set on the edge where pc advances from 2^add_length-1 to 0.

Function
REQ-016 SHALL implement an FSM with states IDLE, FETCH and DRAIN, plus registers pc, instr, instr_addr, instr_valid and wrap.
REQ-017 SHALL define handshake completion (hs) as instr_valid && instr_ready; instr_valid SHALL clear on hs unless a new capture happens on the same edge.
REQ-018 SHALL drive ce = (state==FETCH) && !branch_en && (!instr_valid || instr_ready), combinationally.
REQ-019 SHALL perform a capture on every edge where ce=1, updating registers as follows:
  - instr <= data.
  - instr_addr <= pc.
  - instr_valid <= 1.
  - pc <= pc+1, modulo 2^add_length.
  This gives a one-cycle latency from address to instr, and one instruction per cycle when instr_ready is held high.
REQ-020 SHALL, while instr_valid=1 and instr_ready=0, hold instr, instr_addr and pc stable and keep ce=0 (no overwrite, no skip).
REQ-021 SHALL apply the following FSM transitions:
  - IDLE -> FETCH when enable=1 and branch_en=0.
  - FETCH -> DRAIN when enable=0 and instr_valid=1 and hs=0.
  - FETCH -> IDLE when enable=0 and (instr_valid=0 or hs=1).
  - DRAIN -> IDLE on hs.
  - DRAIN -> FETCH when enable=1 again.
REQ-022 SHALL, in state FETCH with enable=0, make no capture on that edge (ce is still evaluated that cycle, but its capture is suppressed).
REQ-023 SHALL give branch_en=1 priority over all other activity, in any state:
  - pc <= branch_target.
  - instr_valid <= 0, discarding any held instruction even if hs was true that cycle.
  - No capture and no wrap pulse.
  - FSM: FETCH stays FETCH if enable=1, otherwise -> IDLE; DRAIN -> IDLE; IDLE stays IDLE.
REQ-024 SHALL pulse wrap only on a capture at pc=2^add_length-1; branches to 0 SHALL NOT pulse wrap.
REQ-025 SHALL keep ce=0 in IDLE and DRAIN; address SHALL always equal pc.

Reset
REQ-026 SHALL, when rst_n=0, immediately and independent of clk, force:
  - state=IDLE, pc=0, instr=0, instr_addr=0, instr_valid=0, wrap=0.
  - Hence ce=0 and address=0.
REQ-027 SHALL, on reset asserted mid-fetch or mid-stall, discard any pending instruction; after release, the first capture SHALL be from address 0.
REQ-028 SHALL sample no input while rst_n=0 and resume on the first rising clk edge after rst_n goes high.

Verification (memory model mem[i]=16'h1000+i, add_length=3)
REQ-029 SHALL cover: reset release, enable=1, instr_ready=1 held -> instr 1000,1001,...,1007,1000 on consecutive cycles; wrap high exactly one cycle, with instr=1007.
REQ-030 SHALL cover: instr_ready=0 for 3 cycles while instr=1002 -> instr, instr_addr=2 and pc=3 stable, ce=0; ready high -> next instr=1003, no skip or duplicate.
REQ-031 SHALL cover: branch_en=1 with branch_target=5 while instr_valid=1 and instr_ready=0 -> instr_valid=0 next cycle, then instr=1005 with instr_addr=5, then 1006.
REQ-032 SHALL cover: enable dropped while instr=1004 is held and ready=0 -> state DRAIN, ce=0; ready pulse -> instr_valid=0, state IDLE, pc=5 retained.
REQ-033 SHALL cover: rst_n pulsed low between clock edges during a stall -> outputs zero immediately; after release and enable, first instr=1000.
REQ-034 SHALL cover: branch_en=1 on the same edge as hs and a potential capture -> no capture, instr_valid=0, pc=branch_target.
